// File: rtl/hazard_stall_unit_if.sv
// Decode-stage hazard bundle: ID/EX/MEM operand fields in,
// pipeline hold/bubble/flush controls out.
interface hazard_stall_unit_if;
  logic [4:0] IFID_Rs;
  logic [4:0] IFID_Rt;
  logic       ID_UsesRt;
  logic       ID_Branch;
  logic       ID_Redirect;
  logic       IDEX_MemRead;
  logic       IDEX_RegWrite;
  logic [4:0] IDEX_Rd;
  logic       EXMEM_MemRead;
  logic [4:0] EXMEM_Rd;
  logic       PCWrite_Disable;
  logic       IFIDWrite_Disable;
  logic       IDEX_Bubble;
  logic       IFID_Flush;

  modport master (
    output IFID_Rs, IFID_Rt, ID_UsesRt,
    output ID_Branch, ID_Redirect,
    output IDEX_MemRead, IDEX_RegWrite,
    output IDEX_Rd,
    output EXMEM_MemRead, EXMEM_Rd,
    input  PCWrite_Disable,
    input  IFIDWrite_Disable,
    input  IDEX_Bubble, IFID_Flush
  );

  modport slave (
    input  IFID_Rs, IFID_Rt, ID_UsesRt,
    input  ID_Branch, ID_Redirect,
    input  IDEX_MemRead, IDEX_RegWrite,
    input  IDEX_Rd,
    input  EXMEM_MemRead, EXMEM_Rd,
    output PCWrite_Disable,
    output IFIDWrite_Disable,
    output IDEX_Bubble, IFID_Flush
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// Load-use / branch-operand stall and redirect flush control
// for the 5-stage pipeline, with saturating perf counters.
module hazard_stall_unit #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  hazard_stall_unit_if.slave bus,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  typedef enum logic {
    RUN    = 1'b0,
    STALL2 = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic match_x, match_m;
  logic need1, need2;
  logic stall, flush;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    match_x = (bus.IDEX_Rd != 5'd0) &&
              ((bus.IDEX_Rd == bus.IFID_Rs) ||
               (bus.ID_UsesRt &&
                bus.IDEX_Rd == bus.IFID_Rt));
    match_m = (bus.EXMEM_Rd != 5'd0) &&
              ((bus.EXMEM_Rd == bus.IFID_Rs) ||
               (bus.ID_UsesRt &&
                bus.EXMEM_Rd == bus.IFID_Rt));
  end

  // A branch on a just-loaded value waits for both EX and MEM.
  always_comb begin
    need2 = bus.ID_Branch &&
            bus.IDEX_MemRead && match_x;
    need1 = !need2 && (
              (bus.IDEX_MemRead && match_x) ||
              (bus.ID_Branch && bus.IDEX_RegWrite &&
               !bus.IDEX_MemRead && match_x) ||
              (bus.ID_Branch &&
               bus.EXMEM_MemRead && match_m));
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:    if (need2) state_d = STALL2;
      STALL2: state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    stall = 1'b0;
    unique case (state_q)
      RUN:    stall = need1 || need2;
      STALL2: stall = 1'b1;
      default: stall = 1'b0;
    endcase
    if (Reset) stall = 1'b0;
    flush = !Reset && bus.ID_Redirect && !stall;
  end

  assign bus.PCWrite_Disable   = stall;
  assign bus.IFIDWrite_Disable = stall;
  assign bus.IDEX_Bubble       = stall;
  assign bus.IFID_Flush        = flush;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush && (flush_cnt_q != {CNT_W{1'b1}}))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench: remaining-stall-cycles model checked every
// negedge, plus hand-computed literal expectations.
module tb_hazard_stall_unit;

  logic Clk;
  logic Reset;

  logic [4:0] rs, rt, exrd, mrd;
  logic usesrt, br, redir, memrd, regwr, mmemrd;

  logic [15:0] sc0, fc0;
  logic [3:0]  sc1, fc1;

  int vectors;
  int miscompares;

  hazard_stall_unit_if bus0 ();
  hazard_stall_unit_if bus1 ();

  assign bus0.IFID_Rs = rs;
  assign bus0.IFID_Rt = rt;
  assign bus0.ID_UsesRt = usesrt;
  assign bus0.ID_Branch = br;
  assign bus0.ID_Redirect = redir;
  assign bus0.IDEX_MemRead = memrd;
  assign bus0.IDEX_RegWrite = regwr;
  assign bus0.IDEX_Rd = exrd;
  assign bus0.EXMEM_MemRead = mmemrd;
  assign bus0.EXMEM_Rd = mrd;

  assign bus1.IFID_Rs = rs;
  assign bus1.IFID_Rt = rt;
  assign bus1.ID_UsesRt = usesrt;
  assign bus1.ID_Branch = br;
  assign bus1.ID_Redirect = redir;
  assign bus1.IDEX_MemRead = memrd;
  assign bus1.IDEX_RegWrite = regwr;
  assign bus1.IDEX_Rd = exrd;
  assign bus1.EXMEM_MemRead = mmemrd;
  assign bus1.EXMEM_Rd = mrd;

  hazard_stall_unit #(.CNT_W(16)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .bus(bus0.slave),
    .StallCount(sc0),
    .FlushCount(fc0)
  );

  hazard_stall_unit #(.CNT_W(4)) dut_sat (
    .Clk(Clk),
    .Reset(Reset),
    .bus(bus1.slave),
    .StallCount(sc1),
    .FlushCount(fc1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name,
                       input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d",
               name, got, exp);
    end
  endtask

  // Model: number of forced stall cycles still owed,
  // plus plain integer counters clipped at their maximum.
  int rem;
  int m_sc, m_fc, m_sc4, m_fc4;

  function automatic void needs(output bit n1,
                                output bit n2);
    bit mx, mm;
    mx = exrd != 0 && (exrd == rs ||
         (usesrt && exrd == rt));
    mm = mrd != 0 && (mrd == rs ||
         (usesrt && mrd == rt));
    n2 = br && memrd && mx;
    n1 = !n2 && ((memrd && mx) ||
         (br && regwr && !memrd && mx) ||
         (br && mmemrd && mm));
  endfunction

  function automatic bit exp_stall();
    bit n1, n2;
    needs(n1, n2);
    return (rem > 0) || n1 || n2;
  endfunction

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rem = 0;
      m_sc = 0; m_fc = 0;
      m_sc4 = 0; m_fc4 = 0;
    end else begin
      bit n1, n2, s, f;
      needs(n1, n2);
      s = exp_stall();
      f = redir && !s;
      if (s) begin
        if (m_sc < 65535) m_sc++;
        if (m_sc4 < 15) m_sc4++;
      end
      if (f) begin
        if (m_fc < 65535) m_fc++;
        if (m_fc4 < 15) m_fc4++;
      end
      if (rem > 0) rem = rem - 1;
      else if (n2) rem = 1;
    end
  end

  always @(negedge Clk) begin
    bit s, f;
    s = Reset ? 1'b0 : exp_stall();
    f = Reset ? 1'b0 : (redir && !s);
    check("pcw", int'(bus0.PCWrite_Disable), int'(s));
    check("ifidw", int'(bus0.IFIDWrite_Disable), int'(s));
    check("bubble", int'(bus0.IDEX_Bubble), int'(s));
    check("flush", int'(bus0.IFID_Flush), int'(f));
    check("sat_stall", int'(bus1.PCWrite_Disable), int'(s));
    check("sat_flush", int'(bus1.IFID_Flush), int'(f));
    check("stallcnt", int'(sc0), m_sc);
    check("flushcnt", int'(fc0), m_fc);
    check("stallcnt4", int'(sc1), m_sc4);
    check("flushcnt4", int'(fc1), m_fc4);
  end

  task automatic zero();
    rs = 0; rt = 0; exrd = 0; mrd = 0;
    usesrt = 0; br = 0; redir = 0;
    memrd = 0; regwr = 0; mmemrd = 0;
  endtask

  // Drive a vector just after the active edge.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Land just past the negedge model compare.
  task automatic settle();
    @(negedge Clk);
    #1;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    Reset = 1'b1;
    zero();
    repeat (2) @(posedge Clk);
    #1;
    check("rst_pcw", int'(bus0.PCWrite_Disable), 0);
    check("rst_sc", int'(sc0), 0);
    Reset = 1'b0;

    // load-use
    step(); memrd = 1; exrd = 8; rs = 8;
    settle();
    check("lu_stall", int'(bus0.IDEX_Bubble), 1);
    check("lu_sc0", int'(sc0), 0);
    step(); zero();
    settle();
    check("lu_done", int'(bus0.IDEX_Bubble), 0);
    check("lu_sc1", int'(sc0), 1);

    // $0 never a hazard
    step(); memrd = 1; exrd = 0; rs = 0;
    settle();
    check("r0_nostall", int'(bus0.IDEX_Bubble), 0);

    // branch after load: two cycles
    step(); zero();
    br = 1; memrd = 1; exrd = 9; rt = 9; usesrt = 1;
    settle();
    check("bl_c1", int'(bus0.PCWrite_Disable), 1);
    step(); zero();
    settle();
    check("bl_c2", int'(bus0.PCWrite_Disable), 1);
    check("bl_sc2", int'(sc0), 2);
    step();
    settle();
    check("bl_c3", int'(bus0.PCWrite_Disable), 0);
    check("bl_sc3", int'(sc0), 3);

    // branch after ALU op, then after MEM load
    step(); br = 1; regwr = 1; exrd = 5; rs = 5;
    settle();
    check("ba_stall", int'(bus0.PCWrite_Disable), 1);
    step(); zero();
    br = 1; mmemrd = 1; mrd = 5; rs = 5;
    settle();
    check("bm_stall", int'(bus0.PCWrite_Disable), 1);
    step(); zero();
    settle();
    check("bm_done", int'(bus0.PCWrite_Disable), 0);
    check("bm_sc", int'(sc0), 5);

    // non-hazards: rt unused, MEM match w/o branch
    step(); memrd = 1; exrd = 7; rt = 7;
    settle();
    check("rt_unused", int'(bus0.PCWrite_Disable), 0);
    step(); zero(); mmemrd = 1; mrd = 3; rs = 3;
    settle();
    check("mem_nobr", int'(bus0.PCWrite_Disable), 0);
    step(); zero();
    br = 1; regwr = 0; exrd = 4; rs = 4;
    settle();
    check("br_nowr", int'(bus0.PCWrite_Disable), 0);

    // flush
    step(); zero(); redir = 1;
    settle();
    check("fl_on", int'(bus0.IFID_Flush), 1);
    step(); zero();
    settle();
    check("fl_cnt", int'(fc0), 1);
    step(); redir = 1; memrd = 1; exrd = 8; rs = 8;
    settle();
    check("fl_pri", int'(bus0.IFID_Flush), 0);
    check("fl_stall", int'(bus0.IDEX_Bubble), 1);
    step(); zero();
    settle();
    check("fl_cnt2", int'(fc0), 1);
    check("fl_sc", int'(sc0), 6);

    // reset mid-STALL2, redirect ignored there
    step(); br = 1; memrd = 1; exrd = 9; rs = 9;
    step(); zero(); redir = 1;
    #2;
    check("s2_flush", int'(bus0.IFID_Flush), 0);
    check("s2_stall", int'(bus0.IDEX_Bubble), 1);
    Reset = 1'b1;
    #1;
    check("ar_stall", int'(bus0.IDEX_Bubble), 0);
    check("ar_flush", int'(bus0.IFID_Flush), 0);
    check("ar_sc", int'(sc0), 0);
    check("ar_fc", int'(fc0), 0);
    step(); zero(); Reset = 1'b0;
    settle();
    check("post_rst", int'(bus0.PCWrite_Disable), 0);

    // saturation: hold a load-use for 20 cycles
    step(); memrd = 1; exrd = 12; rs = 12;
    repeat (20) @(posedge Clk);
    #1; zero();
    settle();
    check("sat4", int'(sc1), 15);
    check("sat16", int'(sc0), 20);

    step();
    settle();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
